ram256_read_streamer: RTL and testbench
=======================================

# ram256_read_streamer

Read-side sequencer for the 256x32 dual-port scratch RAM's read-only port (port 1). On `start`, it issues a burst of sequential reads from a base address and absorbs the RAM's one-cycle registered read latency. It presents the words as a valid/ready stream with a last-word flag, and a 2-entry skid FIFO keeps backpressure from losing or duplicating data. It sits directly downstream of the RAM and feeds the patch-distance/compare pipeline.

## Interface
- `A_WIDTH`, default 8: RAM address width; depth is 2^A_WIDTH.
- `D_WIDTH`, default 32: RAM word width.
- `CLK`  in  1  single clock, rising edge.
- `RST`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request; accepted only in IDLE.
- `base_addr`  in  A_WIDTH  first address; sampled on accepted `start`.
- `length`  in  A_WIDTH+1  word count 0..256; sampled on accepted `start`; values >256 clamp to 256.
- `busy`  out  1  high from the cycle after an accepted `start` until `done`.
- `done`  out  1  one-cycle pulse when the burst completes.
- `ram_en`  out  1  drives RAM EN1.
- `ram_addr`  out  A_WIDTH  drives RAM A1.
- `ram_dout`  in  D_WIDTH  from RAM Do1; valid only the cycle after `ram_en`=1 (RAM outputs 0 otherwise).
- `out_valid`  out  1  stream valid.
- `out_ready`  in  1  stream ready.
- `out_data`  out  D_WIDTH  stream data.
- `out_last`  out  1  high with the final word of the burst.

## Operation
- **Reset:** FSM to IDLE. `busy`, `done`, `ram_en`, `out_valid`, and `out_last` are 0. `ram_addr` and `out_data` are 0. FIFO is empty; counters and in-flight flag are cleared.
- **States:** IDLE, RUN, DRAIN.
  - IDLE->RUN on `start` with clamped length >0.
  - IDLE stays IDLE on `start` with length 0; `done` pulses the next cycle and no read is issued.
  - RUN->DRAIN when the issued count reaches length.
  - DRAIN->IDLE on the handshake of the `out_last` word. `done` pulses in the same cycle as that IDLE transition.
- **Issue rule:** in RUN, `ram_en`=1 in a cycle only if issued<length and space>0.
  - space = 2 − fifo_occ − inflight + (out_valid && out_ready).
  - `ram_en` may depend combinationally on `out_ready`.
- **Addressing:** `ram_addr` = base_addr + issued, modulo 2^A_WIDTH, so 0xFF wraps to 0x00.
- **Capture:**
  - `inflight` is a register = `ram_en` of the previous cycle.
  - When inflight=1, `ram_dout` is pushed into the FIFO tagged with last = (this word index == length−1).
  - The issue rule guarantees a push never targets a full FIFO, and a push never occurs without a preceding `ram_en`.
- **Stream:** `out_data`/`out_last` come from the FIFO head; `out_valid` = FIFO non-empty. A pop occurs on `out_valid && out_ready`. Push and pop in the same cycle are legal with the FIFO full or empty.
- **Stream rule:** once `out_valid`=1, `out_data`/`out_last` are held stable until the handshake.
- **`start` while busy:** ignored, with no effect on counters or the sampled parameters.
- **`RST` mid-burst:** aborts immediately. FIFO is flushed, in-flight data is discarded, and `done` does not pulse.

## Timing
- `start` accepted in cycle T:
  - `ram_en`=1 with `ram_addr`=base in T+1.
  - Data on `ram_dout` in T+2.
  - `out_valid`=1 in T+3 at the earliest.
- **Throughput:** 1 word/cycle sustained while `out_ready`=1.
- **Burst length:** with `out_ready` held high, a burst of N words completes its last handshake in cycle T+N+2, and `done` pulses in T+N+2.
- **Outstanding work:** at most 2 words (FIFO entries + in-flight) at any time.
- **Recovery:** after `out_ready` returns high following a stall, issue resumes in the same cycle as the first pop.

## Test plan
- **Basic burst:** RAM[0x10..0x13]=0xA0..0xA3; start base=0x10, len=4, `out_ready`=1.
  - Required: `ram_en` in T+1..T+4; `out_data` 0xA0..0xA3 in T+3..T+6; `out_last` only with 0xA3; `done` in T+6.
- **Wrap:** start base=0xFE, len=4.
  - Required: `ram_addr` sequence 0xFE, 0xFF, 0x00, 0x01; data in that order.
- **Backpressure:** len=8; `out_ready`=0 for 10 cycles, then toggled every cycle.
  - Required: never more than 2 words outstanding; all 8 words delivered exactly once and in order; `out_data` stable while stalled.
- **Length 0 and start while busy:**
  - Length 0: `done` next cycle; `ram_en` never high.
  - Second `start` (base=0x40) during a len=4 burst: ignored, only the original 4 words appear.
- **Reset mid-burst:** `RST` during word 3 of a len=16 burst.
  - Required: next cycle all outputs are at reset values and no `done` pulses.
  - A new burst started afterwards is delivered correctly.
- **Full-depth:** len=256 (and len=300, which clamps to 256), `out_ready`=1.
  - Required: 256 words; `done` at T+258; `out_last` on word 255 only.

Source files
------------

// File: rtl/ram256_read_streamer_if.sv
// Bundle of the streamer's control, RAM read-port and output-stream signals.
// master = the streamer itself, slave = the surrounding logic that drives it.
interface ram256_read_streamer_if #(
   parameter int A_WIDTH = 8,
   parameter int D_WIDTH = 32
);
   logic               start;
   logic [A_WIDTH-1:0] base_addr;
   logic [A_WIDTH:0]   length;
   logic               busy;
   logic               done;
   logic               ram_en;
   logic [A_WIDTH-1:0] ram_addr;
   logic [D_WIDTH-1:0] ram_dout;
   logic               out_valid;
   logic               out_ready;
   logic [D_WIDTH-1:0] out_data;
   logic               out_last;

   modport master (
      input  start, base_addr, length, ram_dout, out_ready,
      output busy, done, ram_en, ram_addr, out_valid, out_data, out_last
   );

   modport slave (
      output start, base_addr, length, ram_dout, out_ready,
      input  busy, done, ram_en, ram_addr, out_valid, out_data, out_last
   );
endinterface

// File: rtl/ram256_read_streamer.sv
// Burst read sequencer for the scratch RAM read port: issues sequential reads,
// absorbs the one-cycle read latency and streams words through a 2-entry skid FIFO.
module ram256_read_streamer #(
   parameter int A_WIDTH = 8,
   parameter int D_WIDTH = 32
) (
   input logic                    CLK,
   input logic                    RST,
   ram256_read_streamer_if.master bus
);
   localparam int             DEPTH   = 1 << A_WIDTH;
   localparam logic [A_WIDTH:0] MAX_LEN = DEPTH[A_WIDTH:0];
   localparam logic [A_WIDTH:0] ONE     = 1;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t             state;
   logic [A_WIDTH-1:0] base_q;
   logic [A_WIDTH:0]   len_q;
   logic [A_WIDTH:0]   issued;
   logic [A_WIDTH:0]   captured;
   logic               inflight;
   logic               zero_done;

   logic [D_WIDTH-1:0] fifo_data [2];
   logic               fifo_last [2];
   logic               wptr, rptr;
   logic [1:0]         occ;

   logic [A_WIDTH:0]   len_clamped;
   logic               pop, push, push_last, issue;
   logic [2:0]         used;

   assign len_clamped = (bus.length > MAX_LEN) ? MAX_LEN : bus.length;
   assign pop         = bus.out_valid && bus.out_ready;
   assign push        = inflight;
   assign push_last   = (captured == len_q - ONE);

   // Words already committed (queued or arriving next cycle) must leave room,
   // counting the slot freed by a pop in this same cycle.
   assign used  = {1'b0, occ} + {2'b00, inflight};
   assign issue = (state == RUN) && (issued < len_q) && (used < (3'd2 + {2'b00, pop}));

   assign bus.ram_en    = issue;
   assign bus.ram_addr  = base_q + issued[A_WIDTH-1:0];
   assign bus.out_valid = (occ != 2'd0);
   assign bus.out_data  = fifo_data[rptr];
   assign bus.out_last  = fifo_last[rptr];
   assign bus.busy      = (state != IDLE) || zero_done;
   assign bus.done      = zero_done || ((state == DRAIN) && pop && bus.out_last);

   always_ff @(posedge CLK) begin
      if (RST) begin
         state     <= IDLE;
         base_q    <= '0;
         len_q     <= '0;
         issued    <= '0;
         captured  <= '0;
         inflight  <= 1'b0;
         zero_done <= 1'b0;
         wptr      <= 1'b0;
         rptr      <= 1'b0;
         occ       <= 2'd0;
         for (int i = 0; i < 2; i++) begin
            fifo_data[i] <= '0;
            fifo_last[i] <= 1'b0;
         end
      end else begin
         inflight  <= issue;
         zero_done <= 1'b0;

         if (push) begin
            fifo_data[wptr] <= bus.ram_dout;
            fifo_last[wptr] <= push_last;
            wptr            <= ~wptr;
            captured        <= captured + ONE;
         end
         if (pop)
            rptr <= ~rptr;
         occ <= occ + {1'b0, push} - {1'b0, pop};

         case (state)
            IDLE: begin
               if (bus.start) begin
                  if (len_clamped == '0) begin
                     zero_done <= 1'b1;
                  end else begin
                     base_q   <= bus.base_addr;
                     len_q    <= len_clamped;
                     issued   <= '0;
                     captured <= '0;
                     state    <= RUN;
                  end
               end
            end
            RUN: begin
               if (issue) begin
                  issued <= issued + ONE;
                  if (issued + ONE == len_q)
                     state <= DRAIN;
               end
            end
            DRAIN: begin
               if (pop && bus.out_last)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_ram256_read_streamer.sv
// Directed bench for ram256_read_streamer: queue-based word model checked every
// cycle, plus literal timing/data expectations per scenario.
module tb_ram256_read_streamer;
   logic CLK = 1'b0;
   logic RST;
   always #5 CLK = ~CLK;

   ram256_read_streamer_if #(.A_WIDTH(8), .D_WIDTH(32)) bus ();

   ram256_read_streamer #(.A_WIDTH(8), .D_WIDTH(32)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   logic [31:0] mem [256];
   initial bus.ram_dout = '0;
   always @(posedge CLK) bus.ram_dout <= bus.ram_en ? mem[bus.ram_addr] : 32'h0;

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   typedef struct packed { logic [31:0] d; logic l; } word_t;
   word_t       exp_q [$];
   logic [31:0] hs_log [$];
   logic [7:0]  addr_log [$];
   int checks = 0, failures = 0;
   bit m_act = 0, zpend = 0, rst_seen = 0, stall_prev = 0;
   int n_en = 0, m_len = 0, m_out = 0;
   int t_start = 0, first_en = -1, first_hs = -1, done_cyc = -1;
   logic [7:0]  m_base;
   logic [31:0] prev_d;
   logic        prev_l;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Behavioural model and per-cycle compare.
   always @(negedge CLK) begin
      bit act_now, hs, exp_done;
      if (RST) begin
         exp_q.delete();
         m_act = 0; zpend = 0; m_out = 0; n_en = 0;
         rst_seen = 1; stall_prev = 0;
      end else begin
         if (rst_seen) begin
            chk("rst_busy", bus.busy, 0);
            chk("rst_done", bus.done, 0);
            chk("rst_ram_en", bus.ram_en, 0);
            chk("rst_ram_addr", bus.ram_addr, 0);
            chk("rst_valid", bus.out_valid, 0);
            chk("rst_last", bus.out_last, 0);
            chk("rst_data", bus.out_data, 0);
            rst_seen = 0;
         end
         act_now  = m_act;
         hs       = bus.out_valid && bus.out_ready;
         exp_done = zpend || (hs && exp_q.size() > 0 && exp_q[0].l);
         chk("done", bus.done, exp_done);
         if (bus.done) done_cyc = cyc;
         chk("busy", bus.busy, act_now || zpend);
         chk("outstanding_le2", (m_out <= 2), 1);
         if (stall_prev) begin
            chk("stall_valid", bus.out_valid, 1);
            chk("stall_data", bus.out_data, prev_d);
            chk("stall_last", bus.out_last, prev_l);
         end
         if (hs) begin
            if (exp_q.size() == 0) begin
               checks++; failures++;
               $display("FAIL extra_word: got %h want none (cycle %0d)", bus.out_data, cyc);
            end else begin
               chk("out_data", bus.out_data, exp_q[0].d);
               chk("out_last", bus.out_last, exp_q[0].l);
               if (exp_q[0].l) m_act = 0;
               void'(exp_q.pop_front());
            end
            if (first_hs < 0) first_hs = cyc;
            hs_log.push_back(bus.out_data);
         end
         zpend = 0;
         if (bus.ram_en) begin
            if (!act_now || n_en >= m_len) begin
               checks++; failures++;
               $display("FAIL spurious_ram_en: got 1 want 0 (cycle %0d)", cyc);
            end else begin
               chk("ram_addr", bus.ram_addr, 32'(8'(m_base + n_en)));
            end
            if (first_en < 0) first_en = cyc;
            addr_log.push_back(bus.ram_addr);
            n_en++;
         end
         m_out += int'(bus.ram_en) - int'(hs);
         stall_prev = bus.out_valid && !bus.out_ready;
         prev_d = bus.out_data;
         prev_l = bus.out_last;
         if (bus.start && !act_now) begin
            m_len  = (bus.length > 256) ? 256 : int'(bus.length);
            m_base = bus.base_addr;
            t_start = cyc; first_en = -1; first_hs = -1; done_cyc = -1;
            hs_log.delete(); addr_log.delete();
            if (m_len == 0) zpend = 1;
            else begin
               m_act = 1; n_en = 0;
               for (int i = 0; i < m_len; i++)
                  exp_q.push_back({mem[(int'(m_base) + i) & 255], (i == m_len - 1)});
            end
         end
      end
   end

   task automatic tick();
      @(posedge CLK); #1;
   endtask

   task automatic do_start(input logic [7:0] b, input int l);
      bus.start = 1'b1; bus.base_addr = b; bus.length = 9'(l);
      tick();
      bus.start = 1'b0;
   endtask

   task automatic wait_idle(input int limit);
      int n = 0;
      while ((m_act || zpend || exp_q.size() != 0) && n < limit) begin tick(); n++; end
      checks++;
      if (n >= limit) begin
         failures++;
         $display("FAIL idle_timeout: got %0d cycles want <%0d", n, limit);
      end
      tick();
   endtask

   initial begin
      logic [7:0] wexp [4];
      for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + i * 32'h0001_0101;
      for (int i = 0; i < 4; i++) mem[8'h10 + i] = 32'hA0 + i;
      RST = 1'b1; bus.start = 1'b0; bus.base_addr = '0; bus.length = '0; bus.out_ready = 1'b1;
      repeat (3) tick();
      RST = 1'b0;
      repeat (2) tick();

      // basic burst
      do_start(8'h10, 4);
      wait_idle(50);
      chk("basic_first_en", first_en - t_start, 1);
      chk("basic_first_hs", first_hs - t_start, 3);
      chk("basic_done_cyc", done_cyc - t_start, 6);
      chk("basic_count", hs_log.size(), 4);
      for (int i = 0; i < 4 && i < hs_log.size(); i++) chk("basic_data", hs_log[i], 32'hA0 + i);

      // address wrap
      do_start(8'hFE, 4);
      wait_idle(50);
      wexp = '{8'hFE, 8'hFF, 8'h00, 8'h01};
      chk("wrap_count", addr_log.size(), 4);
      for (int i = 0; i < 4 && i < addr_log.size(); i++) chk("wrap_addr", addr_log[i], wexp[i]);
      if (hs_log.size() > 2) chk("wrap_data2", hs_log[2], 32'h1000_0000);

      // backpressure
      bus.out_ready = 1'b0;
      do_start(8'h20, 8);
      repeat (9) tick();
      for (int n = 0; n < 200 && (m_act || exp_q.size() != 0); n++) begin
         bus.out_ready = ~bus.out_ready;
         tick();
      end
      bus.out_ready = 1'b1;
      wait_idle(20);
      chk("bp_count", hs_log.size(), 8);
      if (hs_log.size() == 8) begin
         chk("bp_first", hs_log[0], 32'h1020_2020);
         chk("bp_last", hs_log[7], 32'h1027_2727);
      end

      // length zero
      do_start(8'h33, 0);
      wait_idle(10);
      chk("len0_done_cyc", done_cyc - t_start, 1);
      chk("len0_no_en", first_en, -1);

      // start while busy is ignored
      do_start(8'h50, 4);
      tick();
      do_start(8'h40, 4);
      wait_idle(50);
      chk("busy_start_count", hs_log.size(), 4);
      if (hs_log.size() > 0) chk("busy_start_first", hs_log[0], 32'h1050_5050);

      // reset during word 3 of a 16-word burst
      do_start(8'h60, 16);
      repeat (4) tick();
      RST = 1'b1;
      tick();
      RST = 1'b0;
      repeat (3) tick();
      do_start(8'h70, 3);
      wait_idle(50);
      chk("post_rst_count", hs_log.size(), 3);
      if (hs_log.size() == 3) chk("post_rst_data", hs_log[2], 32'h1072_7272);
      chk("post_rst_done", done_cyc - t_start, 5);

      // full depth and clamped length
      do_start(8'h00, 256);
      wait_idle(600);
      chk("full_count", hs_log.size(), 256);
      chk("full_done_cyc", done_cyc - t_start, 258);
      do_start(8'h80, 300);
      wait_idle(600);
      chk("clamp_count", hs_log.size(), 256);
      chk("clamp_done_cyc", done_cyc - t_start, 258);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
